dadda_reduce_stage: RTL



---
 rtl/dadda_reduce_stage_if.sv | 24 ++
 rtl/dadda_reduce_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dadda_reduce_stage_if.sv
// Valid/ready channel bundle for one Dadda reduction stage: input matrix in, reduced matrix out.
// A transfer happens on a rising clk edge where valid and ready are both high; data is stable while valid && !ready.
interface dadda_reduce_stage_if #(
    parameter int WIDTH  = 48,
    parameter int ROWS   = 9,
    parameter int TARGET = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*WIDTH-1:0]   in_rows;
    logic                    out_valid;
    logic                    out_ready;
    logic [TARGET*WIDTH-1:0] out_rows;

    modport slave (
        input  in_valid, in_rows, out_ready,
        output in_ready, out_valid, out_rows
    );

    modport master (
        output in_valid, in_rows, out_ready,
        input  in_ready, out_valid, out_rows
    );
endinterface

// File: rtl/dadda_reduce_stage.sv
// One registered Dadda reduction level: ROWS x WIDTH bit matrix -> TARGET rows, sum preserved mod 2^WIDTH.
// Optional sum checker enabled by defining DADDA_SUM_CHECK_EN; otherwise sum_err is tied low.
module dadda_reduce_stage #(
    parameter int WIDTH  = 48,
    parameter int ROWS   = 9,
    parameter int TARGET = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dadda_reduce_stage_if.slave  bus,
    output logic                 sum_err
);

    // Carries entering a column; column heights converge to 2*ROWS-TARGET.
    function automatic int carries_into(input int col);
        int c;
        int h;
        c = 0;
        for (int k = 0; k < col; k++) begin
            h = ROWS + c;
            c = (h > TARGET) ? ((h - TARGET + 1) / 2) : 0;
        end
        return c;
    endfunction

    localparam int MAXC = carries_into(WIDTH - 1);

    if (!(TARGET >= 2 && TARGET < ROWS && ROWS <= (3 * TARGET) / 2)) begin : g_bad_params
        $error("dadda_reduce_stage: need 2 <= TARGET < ROWS <= 3*TARGET/2");
    end

    logic [MAXC-1:0]         cy_w [WIDTH-1];
    logic [TARGET*WIDTH-1:0] red_w;

    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        localparam int CIN   = carries_into(j);
        localparam int HIN   = ROWS + CIN;
        localparam int NFA   = (HIN - TARGET) / 2;
        localparam int NHA   = (HIN - TARGET) % 2;
        localparam int NA    = NFA + NHA;
        localparam int USED  = 3 * NFA + 2 * NHA;
        localparam int NSURV = ROWS - USED;
        localparam int HOUT  = NSURV + NA + CIN;

        logic [HIN-1:0] bits_w;
        logic [NA-1:0]  sum_w;

        for (genvar r = 0; r < ROWS; r++) begin : g_in
            assign bits_w[r] = bus.in_rows[r*WIDTH + j];
        end
        if (CIN > 0) begin : g_cin
            assign bits_w[HIN-1:ROWS] = cy_w[j-1][CIN-1:0];
        end

        // Adders only ever consume input bits because ROWS <= 3*TARGET/2.
        for (genvar a = 0; a < NFA; a++) begin : g_fa
            assign sum_w[a] = bits_w[3*a] ^ bits_w[3*a+1] ^ bits_w[3*a+2];
        end
        if (NHA > 0) begin : g_ha
            assign sum_w[NFA] = bits_w[3*NFA] ^ bits_w[3*NFA+1];
        end

        if (j < WIDTH - 1) begin : g_cout
            for (genvar a = 0; a < NFA; a++) begin : g_fa_c
                assign cy_w[j][a] = (bits_w[3*a] & bits_w[3*a+1]) |
                                    (bits_w[3*a] & bits_w[3*a+2]) |
                                    (bits_w[3*a+1] & bits_w[3*a+2]);
            end
            if (NHA > 0) begin : g_ha_c
                assign cy_w[j][NFA] = bits_w[3*NFA] & bits_w[3*NFA+1];
            end
            if (NA < MAXC) begin : g_pad
                assign cy_w[j][MAXC-1:NA] = '0;
            end
        end

        if (HOUT > TARGET) begin : g_bad_height
            $error("dadda_reduce_stage: column height exceeds TARGET");
        end

        // Pack: surviving inputs, then adder sums, then incoming carries.
        for (genvar t = 0; t < TARGET; t++) begin : g_pack
            if (t < NSURV) begin : g_surv
                assign red_w[t*WIDTH + j] = bits_w[USED + t];
            end else if (t < NSURV + NA) begin : g_sum
                assign red_w[t*WIDTH + j] = sum_w[t - NSURV];
            end else if (t < HOUT) begin : g_carry
                assign red_w[t*WIDTH + j] = bits_w[ROWS + t - NSURV - NA];
            end else begin : g_zero
                assign red_w[t*WIDTH + j] = 1'b0;
            end
        end
    end

    logic                    out_valid_q;
    logic [TARGET*WIDTH-1:0] out_rows_q;
    logic [31:0]             xfer_cnt_q;
    logic                    load_w;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign load_w        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rows  = out_rows_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_rows_q  <= '0;
            xfer_cnt_q  <= '0;
        end else if (load_w) begin
            out_valid_q <= 1'b1;
            out_rows_q  <= red_w;
            xfer_cnt_q  <= xfer_cnt_q + 32'd1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef DADDA_SUM_CHECK_EN
    logic [WIDTH-1:0] in_sum_w;
    logic [WIDTH-1:0] red_sum_w;
    logic             sum_err_q;

    always_comb begin
        in_sum_w  = '0;
        red_sum_w = '0;
        for (int r = 0; r < ROWS; r++) begin
            in_sum_w = in_sum_w + bus.in_rows[r*WIDTH +: WIDTH];
        end
        for (int t = 0; t < TARGET; t++) begin
            red_sum_w = red_sum_w + red_w[t*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err_q <= 1'b0;
        end else if (load_w && (in_sum_w != red_sum_w)) begin
            sum_err_q <= 1'b1;
        end
    end

    assign sum_err = sum_err_q;
`else
    assign sum_err = 1'b0;
`endif

endmodule
